multi_shift_reg: RTL and testbench
==================================

MULTI_SHIFT_REG -- requirements
Module: multi_shift_reg

Interface
REQ-001 The block SHALL have parameter N, default 8: register width, N >= 2.
REQ-002 The block SHALL have localparam AW = $clog2(N)+1: shift-count width.
REQ-003 The block SHALL have port clk, input, 1: clock; rising edge active.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: command request; sampled on clk.
REQ-006 The block SHALL have port op, input, 3: command code (REQ-011).
REQ-007 The block SHALL have port amt, input, AW: shift step count, 0..N.
REQ-008 The block SHALL have port d, input, N: parallel load data.
REQ-009 The block SHALL have port sin, input, 1: serial fill bit for SHL/SHR; sampled at every step edge.
REQ-010 The block SHALL have outputs q (N: register contents), sout (1: last bit shifted out), busy (1: multi-step command running) and done (1: one-cycle completion pulse).

Function
REQ-011 op encoding SHALL be: 000 NOP, 001 LOAD, 010 SHL (lsb <- sin), 011 SHR (msb <- sin), 100 ROL, 101 ROR, 110 ASR (msb replicated), 111 CLR.
REQ-012 FSM SHALL have two states: IDLE and SHIFT; busy = (state == SHIFT).
REQ-013 A command SHALL be accepted on a rising edge where start=1 and busy=0; start while busy=1 SHALL be ignored with no effect.
REQ-014 LOAD, CLR and NOP SHALL complete at the accept edge: q <= d, 0 or unchanged respectively; done=1 for the following cycle; state remains IDLE.
REQ-015 A shift op with amt=0 SHALL complete at the accept edge with q and sout unchanged and done=1 for the following cycle.
REQ-016 A shift op with amt=K (1..N) SHALL latch op and K at the accept edge, leave q unchanged and enter SHIFT.
REQ-017 In SHIFT, each edge SHALL perform exactly one 1-bit step of the latched op and decrement the remaining count.
REQ-018 The edge performing step K SHALL return the FSM to IDLE and assert done for one cycle; busy is therefore high for exactly K cycles.
REQ-019 sout SHALL register the bit leaving the register on each step: q[N-1] for SHL/ROL, q[0] for SHR/ROR/ASR. sout SHALL hold its value otherwise.
REQ-020 amt > N SHALL be saturated to N.
REQ-021 done SHALL be low in every cycle not named in REQ-014/015/018.
REQ-022 A new command MAY be accepted in the cycle where done=1 (back-to-back, no bubble).
REQ-023 op, amt and d changes during SHIFT SHALL have no effect; sin SHALL be live.

Reset
REQ-024 reset=1 SHALL immediately force q=0, sout=0, busy=0, done=0, state IDLE and count 0, including mid-command. An aborted command SHALL NOT produce done.
REQ-025 After reset deasserts, the first rising edge SHALL be able to accept a command.

Structure
REQ-026 A shared package shift_pkg SHALL hold the op code constants/enum and the FSM state type.
REQ-027 Next-value logic SHALL be kept separate from the state/register process.
REQ-028 One combinational sub-module, shift_step (N-param; inputs q, op, sin; outputs next q and out bit), SHALL implement a single step.

Verification (N=8)
REQ-029 Reset test: assert reset mid-run -> q=0x00, busy=0, done=0, sout=0 immediately.
REQ-030 LOAD test: LOAD d=0xA5 -> q=0xA5 after 1 edge; done high exactly 1 cycle; busy never high.
REQ-031 ROL test: from q=0xA5, ROL amt=3 -> busy high 3 cycles; q=0x2D; sout=1; done 1 cycle after the 3rd step.
REQ-032 ASR test: from q=0x84, ASR amt=2 -> q=0xE1, sout=0. Then SHL amt=2 with sin=1 -> q=0x87, sout=1.
REQ-033 Ignored/boundary test: start ROR during busy -> ignored. SHR amt=0 -> done next cycle, q unchanged. SHR amt=8 with sin=0 on 0xFF -> q=0x00 after 8 steps.
REQ-034 Reset/back-to-back test: reset at step 2 of a 5-step shift -> no done. A command issued in the done cycle -> accepted at that edge.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-step shift register: command codes,
// FSM state type and a helper that classifies multi-step commands.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for commands that move bits and therefore honour amt.
  function automatic logic is_shift_op(input op_t o);
    logic r;
    case (o)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One 1-bit step of a shift/rotate command. Purely combinational; the
// caller decides when the result is committed.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  logic [2:0]   op,
  input  logic         sin,
  output logic [N-1:0] q_next,
  output logic         out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op_t'(op))
      OP_SHL: begin
        q_next  = {q[N-2:0], sin};
        out_bit = q[N-1];
      end
      OP_SHR: begin
        q_next  = {sin, q[N-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        q_next  = {q[N-2:0], q[N-1]};
        out_bit = q[N-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[N-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        q_next  = {q[N-1], q[N-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_shift_reg.sv
// N-bit register executing load/clear and multi-step shift/rotate commands,
// one bit per clock, with a busy flag and a one-cycle done pulse.
module multi_shift_reg
  import shift_pkg::*;
#(
  parameter  int N  = 8,
  localparam int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          sin,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  // Handshake: a command (op/amt/d) is taken on any rising edge where
  // start=1 and busy=0; start is ignored while busy=1. Completion is
  // signalled by done=1 for exactly one cycle, during which a new command
  // may already be taken.

  localparam logic [AW-1:0] N_AW = AW'(N);

  state_t        state, state_nxt;
  op_t           op_q, op_q_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] amt_sat;
  logic [N-1:0]  q_nxt;
  logic          sout_nxt;
  logic          done_nxt;
  logic [N-1:0]  step_q;
  logic          step_out;

  shift_step #(.N(N)) u_step (
    .q      (q),
    .op     (op_q),
    .sin    (sin),
    .q_next (step_q),
    .out_bit(step_out)
  );

  assign busy    = (state == ST_SHIFT);
  assign amt_sat = (amt > N_AW) ? N_AW : amt;

  always_comb begin
    state_nxt = state;
    op_q_nxt  = op_q;
    cnt_nxt   = cnt;
    q_nxt     = q;
    sout_nxt  = sout;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(op_t'(op))) begin
            if (amt_sat == '0) begin
              done_nxt = 1'b1;
            end else begin
              op_q_nxt  = op_t'(op);
              cnt_nxt   = amt_sat;
              state_nxt = ST_SHIFT;
            end
          end else begin
            if (op_t'(op) == OP_LOAD) q_nxt = d;
            if (op_t'(op) == OP_CLR)  q_nxt = '0;
            done_nxt = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        q_nxt    = step_q;
        sout_nxt = step_out;
        cnt_nxt  = cnt - AW'(1);
        // The edge taking the last step also finishes the command.
        if (cnt == AW'(1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= OP_NOP;
      cnt   <= '0;
      q     <= '0;
      sout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op_q  <= op_q_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      sout  <= sout_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_multi_shift_reg.sv
// Directed bench for multi_shift_reg (N=8) with hand-computed expectations.
module tb_multi_shift_reg;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       sout, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  multi_shift_reg #(.N(8)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .amt  (amt),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Present one command for a single edge; returns 1 time unit after that edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dv);
    start = 1'b1; op = o; amt = a; d = dv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    issue(LOAD, 4'd0, v);
    check("load q", q, v);
    check("load done", done, 1);
    @(posedge clk); #1;
  endtask

  // Run a shift command to completion, optionally poking a command mid-run.
  task automatic run_shift(input string tag, input logic [2:0] o, input logic [3:0] a,
                           input logic s, input bit inject, input int exp_k);
    int  n;
    bit  early_done;
    n = 0; early_done = 0;
    sin = s;
    issue(o, a, 8'h00);
    while (busy && n < 40) begin
      n++;
      if (done) early_done = 1;
      if (inject && n == 1) begin
        start = 1'b1; op = ROR; amt = 4'd1; d = 8'h00;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check({tag, " busy cycles"}, n, exp_k);
    check({tag, " done"}, done, 1);
    check({tag, " done while busy"}, early_done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = NOP; amt = '0; d = '0; sin = 1'b0;
    #1;
    check("rst q", q, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sout", sout, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // LOAD completes at the accept edge, done for one cycle, never busy
    issue(LOAD, 4'd0, 8'hA5);
    check("load a5 q", q, 8'hA5);
    check("load a5 done", done, 1);
    check("load a5 busy", busy, 0);
    @(posedge clk); #1;
    check("load a5 done gone", done, 0);

    // ROL 3 of A5: 4B -> 96 -> 2D, last bit out 1
    run_shift("rol3", ROL, 4'd3, 1'b0, 0, 3);
    check("rol3 q", q, 8'h2D);
    check("rol3 sout", sout, 1);
    @(posedge clk); #1;
    check("rol3 done gone", done, 0);

    // ASR 2 of 84: C2 -> E1, then SHL 2 with sin=1: C3 -> 87
    load(8'h84);
    run_shift("asr2", ASR, 4'd2, 1'b0, 0, 2);
    check("asr2 q", q, 8'hE1);
    check("asr2 sout", sout, 0);
    @(posedge clk); #1;
    run_shift("shl2", SHL, 4'd2, 1'b1, 0, 2);
    check("shl2 q", q, 8'h87);
    check("shl2 sout", sout, 1);
    @(posedge clk); #1;

    // ROR command during busy is ignored: ROL 4 of 81 -> 18, sout 0
    load(8'h81);
    run_shift("rol4 ign", ROL, 4'd4, 1'b0, 1, 4);
    check("rol4 ign q", q, 8'h18);
    check("rol4 ign sout", sout, 0);
    @(posedge clk); #1;
    check("rol4 ign idle", busy, 0);

    // SHR amt=0: done next cycle, q and sout unchanged
    issue(SHR, 4'd0, 8'h00);
    check("shr0 done", done, 1);
    check("shr0 busy", busy, 0);
    check("shr0 q", q, 8'h18);
    check("shr0 sout", sout, 0);
    @(posedge clk); #1;

    // SHR 8 with sin=0 on FF empties it; last bit out is 1
    load(8'hFF);
    run_shift("shr8", SHR, 4'd8, 1'b0, 0, 8);
    check("shr8 q", q, 8'h00);
    check("shr8 sout", sout, 1);
    @(posedge clk); #1;

    // amt=15 saturates to 8: full rotate returns the original value
    load(8'h3C);
    run_shift("ror15", ROR, 4'd15, 1'b0, 0, 8);
    check("ror15 q", q, 8'h3C);
    @(posedge clk); #1;

    // NOP keeps q, CLR zeroes it
    issue(NOP, 4'd0, 8'hFF);
    check("nop q", q, 8'h3C);
    check("nop done", done, 1);
    @(posedge clk); #1;
    issue(CLR, 4'd0, 8'hFF);
    check("clr q", q, 8'h00);
    check("clr done", done, 1);
    @(posedge clk); #1;

    // Reset at step 2 of a 5-step SHL: immediate clear, no done afterwards
    load(8'hF0);
    sin = 1'b0;
    issue(SHL, 4'd5, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid q before rst", q, 8'hC0);
    reset = 1'b1;
    #1;
    check("mid rst q", q, 0);
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst sout", sout, 0);
    begin
      bit saw_done;
      saw_done = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (done || busy) saw_done = 1;
        @(posedge clk); #1;
      end
      check("aborted no done", saw_done, 0);
    end

    // First edge after reset release accepts a command
    reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(LOAD, 4'd0, 8'h5A);
    check("post rst load q", q, 8'h5A);
    @(posedge clk); #1;

    // Back-to-back: command in the done cycle of ROL 2 (01 -> 02 -> 04)
    load(8'h01);
    run_shift("rol2", ROL, 4'd2, 1'b0, 0, 2);
    check("rol2 q", q, 8'h04);
    issue(LOAD, 4'd0, 8'h77);
    check("b2b load q", q, 8'h77);
    check("b2b load done", done, 1);
    run_shift("b2b shr1", SHR, 4'd1, 1'b1, 0, 1);
    check("b2b shr1 q", q, 8'hBB);
    check("b2b shr1 sout", sout, 1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
